dmem_ctrl: RTL and testbench

Parametrised data-memory controller between the MIPS core's load/store port and an on-chip data RAM; supersedes the fixed single-cycle, word-only data memory. Adds byte/halfword/word accesses with byte-lane enables, sign/zero load extension, misalignment detection, and a configurable wait-state latency with a stall/ready handshake to the core.

---
 rtl/dmem_ctrl_pkg.sv | 57 +++++
 rtl/dmem_ctrl_if.sv | 23 ++
 rtl/dmem_ram.sv | 25 ++
 rtl/dmem_ctrl.sv | 142 ++++++++++++++
 tb/tb_dmem_ctrl.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and byte-lane helpers for the data-memory controller.
package dmem_ctrl_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Encoding 2'b11 falls into the default branches and behaves as a word.
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: is_misaligned = 1'b0;
            SZ_HALF: is_misaligned = a[0];
            default: is_misaligned = (a != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: lane_en = 4'b0001 << a;
            SZ_HALF: lane_en = a[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            SZ_BYTE: store_data = {4{d[7:0]}};
            SZ_HALF: store_data = {2{d[15:0]}};
            default: store_data = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic [1:0] a,
                                                input logic sx, input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            SZ_BYTE: load_extend = {{24{sx & b[7]}}, b};
            SZ_HALF: load_extend = {{16{sx & h[15]}}, h};
            default: load_extend = w;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core load/store port of the data-memory controller.
interface dmem_ctrl_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign_ext;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        stall;
    logic        misalign;

    modport master (
        output req, we, size, sign_ext, addr, wdata,
        input  rdata, ready, stall, misalign
    );

    modport slave (
        input  req, we, size, sign_ext, addr, wdata,
        output rdata, ready, stall, misalign
    );
endinterface

// File: rtl/dmem_ram.sv
// Single-port 32-bit RAM with per-byte write enables; read-first on a write.
module dmem_ram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            rdata <= mem[addr];
            for (int i = 0; i < 4; i++) begin
                if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: sized/aligned accesses with configurable wait states.
// Optional access/stall counters are enabled with DMEM_CTRL_STATS_EN.
//
// state | meaning
// IDLE  | waiting for req; request fields latched on accept
// WAIT  | wait-state countdown; RAM access on the edge leaving the last count
// DONE  | one-cycle ready pulse; rdata/misalign valid
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
`ifdef DMEM_CTRL_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] stall_count
`endif
);
    localparam logic [3:0] WS_INIT = 4'(WAIT_STATES);
    localparam bit         NO_WAIT = (WAIT_STATES == 0);
    localparam int         AW      = ADDR_WIDTH + 2;

    state_t          state, state_nxt;
    logic [3:0]      cnt;
    logic            we_q, sext_q, err_q;
    logic [1:0]      size_q;
    logic [AW-1:0]   addr_q;
    logic [31:0]     wdata_q;

    logic            accept, mis_in;
    logic            cur_we;
    logic [1:0]      cur_size;
    logic [AW-1:0]   cur_addr;
    logic [31:0]     cur_wdata;
    logic            ram_en;
    logic [3:0]      ram_we;
    logic [31:0]     ram_wdata, ram_q;
    logic            ready, misalign, stall;
    logic [31:0]     rdata;

    // Upper address bits wrap silently onto the RAM.
    logic            unused_addr_hi;
    assign unused_addr_hi = ^bus.addr[31:AW];

    assign accept = (state == ST_IDLE) && bus.req;
    assign mis_in = is_misaligned(bus.size, bus.addr[1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            sext_q  <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q    <= bus.we;
                sext_q  <= bus.sign_ext;
                size_q  <= bus.size;
                addr_q  <= bus.addr[AW-1:0];
                wdata_q <= bus.wdata;
                err_q   <= mis_in;
                cnt     <= WS_INIT;
            end else if (state == ST_WAIT) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.req) state_nxt = (mis_in || NO_WAIT) ? ST_DONE : ST_WAIT;
            ST_WAIT: if (cnt <= 4'd1) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        // With no wait states the access happens on the accept edge, so the
        // RAM is fed straight from the bus while idle.
        cur_we    = we_q;
        cur_size  = size_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        if (state == ST_IDLE) begin
            cur_we    = bus.we;
            cur_size  = bus.size;
            cur_addr  = bus.addr[AW-1:0];
            cur_wdata = bus.wdata;
        end
        ram_en    = ~rst & ((accept & ~mis_in & NO_WAIT) |
                            ((state == ST_WAIT) && (cnt <= 4'd1)));
        ram_we    = (ram_en & cur_we) ? lane_en(cur_size, cur_addr[1:0]) : 4'b0000;
        ram_wdata = store_data(cur_size, cur_wdata);

        ready    = (state == ST_DONE);
        misalign = ready & err_q;
        stall    = bus.req & ~ready;
        rdata    = '0;
        if (ready && !err_q && !we_q) rdata = load_extend(size_q, addr_q[1:0], sext_q, ram_q);
    end

    assign bus.ready    = ready;
    assign bus.misalign = misalign;
    assign bus.stall    = stall;
    assign bus.rdata    = rdata;

    dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (cur_addr[AW-1:2]),
        .wdata (ram_wdata),
        .rdata (ram_q)
    );

`ifdef DMEM_CTRL_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count    <= '0;
            wr_count    <= '0;
            stall_count <= '0;
        end else begin
            if (ready && !err_q && !we_q) rd_count <= rd_count + 32'd1;
            if (ready && !err_q && we_q)  wr_count <= wr_count + 32'd1;
            if (stall)                    stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed-vector bench: WAIT_STATES=2 instance (a) and WAIT_STATES=0 instance (b).
module tb_dmem_ctrl;
    import dmem_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, req_b;
    logic        we_t, sext_t;
    logic [1:0]  size_t;
    logic [31:0] addr_t, wdata_t;

    int n_vec  = 0;
    int n_miss = 0;

    dmem_ctrl_if bus_a ();
    dmem_ctrl_if bus_b ();

    assign bus_a.req = req_a;      assign bus_b.req = req_b;
    assign bus_a.we = we_t;        assign bus_b.we = we_t;
    assign bus_a.size = size_t;    assign bus_b.size = size_t;
    assign bus_a.sign_ext = sext_t; assign bus_b.sign_ext = sext_t;
    assign bus_a.addr = addr_t;    assign bus_b.addr = addr_t;
    assign bus_a.wdata = wdata_t;  assign bus_b.wdata = wdata_t;

`ifdef DMEM_CTRL_STATS_EN
    logic [31:0] rd_cnt_a, wr_cnt_a, st_cnt_a;
    logic [31:0] rd_cnt_b, wr_cnt_b, st_cnt_b;
`endif

    dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut_a (
        .clk (clk), .rst (rst), .bus (bus_a)
`ifdef DMEM_CTRL_STATS_EN
        , .rd_count (rd_cnt_a), .wr_count (wr_cnt_a), .stall_count (st_cnt_a)
`endif
    );

    dmem_ctrl #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut_b (
        .clk (clk), .rst (rst), .bus (bus_b)
`ifdef DMEM_CTRL_STATS_EN
        , .rd_count (rd_cnt_b), .wr_count (wr_cnt_b), .stall_count (st_cnt_b)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; that cycle is cycle 0 of the access.
    // Inputs are scrambled from cycle 1 on so only latched values may matter.
    task automatic access(input bit sel, input bit w, input logic [1:0] sz, input bit sx,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output int rcyc, output bit mis,
                          output int nstall);
        logic rdy, stl;
        we_t = w; size_t = sz; sext_t = sx; addr_t = a; wdata_t = d;
        if (sel) req_b = 1'b1; else req_a = 1'b1;
        rd = '0; rcyc = -1; mis = 1'b0; nstall = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            rdy = sel ? bus_b.ready : bus_a.ready;
            stl = sel ? bus_b.stall : bus_a.stall;
            if (stl) nstall++;
            if (rdy) begin
                rd   = sel ? bus_b.rdata : bus_a.rdata;
                mis  = sel ? bus_b.misalign : bus_a.misalign;
                rcyc = c;
                break;
            end
            @(posedge clk); #1;
            if (c == 0) begin
                we_t = ~w; size_t = ~sz; sext_t = ~sx; addr_t = ~a; wdata_t = ~d;
            end
        end
        @(posedge clk); #1;
        req_a = 1'b0; req_b = 1'b0;
    endtask

    task automatic run_chk(input string tag, input bit sel, input bit w, input logic [1:0] sz,
                           input bit sx, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd, input int exp_cyc, input bit exp_mis);
        logic [31:0] rd;
        int          rcyc, nst;
        bit          mis;
        access(sel, w, sz, sx, a, d, rd, rcyc, mis, nst);
        check_val({tag, "/rdata"}, rd, exp_rd);
        check_val({tag, "/ready_cycle"}, rcyc, exp_cyc);
        check_val({tag, "/misalign"}, {31'd0, mis}, {31'd0, exp_mis});
        check_val({tag, "/stall_cycles"}, nst, exp_cyc);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; req_a = 1'b0; req_b = 1'b0;
        we_t = 1'b0; sext_t = 1'b0; size_t = SZ_WORD; addr_t = '0; wdata_t = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check_val("rst/ready",    {31'd0, bus_a.ready},    32'd0);
        check_val("rst/misalign", {31'd0, bus_a.misalign}, 32'd0);
        check_val("rst/rdata",    bus_a.rdata,             32'd0);
        check_val("rst/stall",    {31'd0, bus_a.stall},    32'd0);
        check_val("rst/rdata_b",  bus_b.rdata,             32'd0);
        @(posedge clk); #1;

        run_chk("st_word",   0, 1, SZ_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0,        3, 0);
        run_chk("ld_byte_s", 0, 0, SZ_BYTE, 1, 32'h13, 32'h0,        32'hFFFFFFDE, 3, 0);
        run_chk("ld_half_z", 0, 0, SZ_HALF, 0, 32'h12, 32'h0,        32'h0000DEAD, 3, 0);
        run_chk("st_byte",   0, 1, SZ_BYTE, 0, 32'h11, 32'h00000055, 32'h0,        3, 0);
        run_chk("ld_word",   0, 0, SZ_WORD, 0, 32'h10, 32'h0,        32'hDEAD55EF, 3, 0);
        run_chk("ld_half_s0",0, 0, SZ_HALF, 1, 32'h10, 32'h0,        32'h000055EF, 3, 0);
        run_chk("ld_half_s1",0, 0, SZ_HALF, 1, 32'h12, 32'h0,        32'hFFFFDEAD, 3, 0);
        run_chk("ld_byte_z", 0, 0, SZ_BYTE, 0, 32'h13, 32'h0,        32'h000000DE, 3, 0);
        run_chk("mis_word",  0, 0, SZ_WORD, 0, 32'h12, 32'h0,        32'h0,        1, 1);
        run_chk("mis_st",    0, 1, SZ_HALF, 0, 32'h11, 32'h0000AAAA, 32'h0,        1, 1);
        run_chk("ld_after",  0, 0, SZ_WORD, 0, 32'h10, 32'h0,        32'hDEAD55EF, 3, 0);
        run_chk("size11",    0, 0, 2'b11,   1, 32'h10, 32'h0,        32'hDEAD55EF, 3, 0);

        run_chk("st_prior",  0, 1, SZ_WORD, 0, 32'h20, 32'hCAFEF00D, 32'h0,        3, 0);
        we_t = 1'b1; size_t = SZ_WORD; sext_t = 1'b0; addr_t = 32'h20; wdata_t = 32'h12345678;
        req_a = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0; req_a = 1'b0;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus_a.ready) seen++;
        end
        check_val("rst_mid/no_ready", seen, 32'd0);
        @(posedge clk); #1;
        run_chk("rst_mid/ld",  0, 0, SZ_WORD, 0, 32'h20,   32'h0,        32'hCAFEF00D, 3, 0);
        run_chk("alias_ld",    0, 0, SZ_WORD, 0, 32'h1020, 32'h0,        32'hCAFEF00D, 3, 0);
        run_chk("alias_st",    0, 1, SZ_HALF, 0, 32'h1022, 32'h0000BEEF, 32'h0,        3, 0);
        run_chk("alias_chk",   0, 0, SZ_WORD, 0, 32'h20,   32'h0,        32'hBEEFF00D, 3, 0);

        // Zero-wait instance: store then load issued back-to-back.
        run_chk("ws0_st", 1, 1, SZ_WORD, 0, 32'h40, 32'hA5A50F0F, 32'h0,        1, 0);
        run_chk("ws0_ld", 1, 0, SZ_WORD, 0, 32'h40, 32'h0,        32'hA5A50F0F, 1, 0);
`ifdef DMEM_CTRL_STATS_EN
        check_val("stats/rd_count",    rd_cnt_b, 32'd1);
        check_val("stats/wr_count",    wr_cnt_b, 32'd1);
        check_val("stats/stall_count", st_cnt_b, 32'd2);
`endif
        run_chk("ws0_mis",  1, 0, SZ_HALF, 0, 32'h41, 32'h0,        32'h0,        1, 1);
        run_chk("ws0_byte", 1, 0, SZ_BYTE, 1, 32'h42, 32'h0,        32'hFFFFFFA5, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
